mod_add_sub_seq: RTL and testbench
==================================

Name: mod_add_sub_seq

Overview:
- Limb-serial sequencer that computes R = (A + B) mod P or R = (A − B) mod P over LIMBS words of W bits.
- Reads operand limbs from the ECC operand memories and drives two W-bit adder instances in a carry chain.
  - Chain 1: S = A ± B.
  - Chain 2: T = S ∓ P.
- Writes S and T limbs to the result memory banks each cycle.
- At the end, flags which bank holds the reduced result.
- Sits between the ECC arithmetic-unit controller and the operand/result RAMs.

Parameters:
W, 32, limb width in bits (width of each adder instance)
LIMBS, 12, number of limbs per operand (12×32 = 384 bits)
AW, 4, limb address width; must satisfy 2^AW ≥ LIMBS

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
start_i  in  1  one-cycle request; sampled only in IDLE
sub_i  in  1  operation select, sampled with start_i: 0 = add, 1 = subtract
busy_o  out  1  high while an operation is in progress
done_o  out  1  one-cycle pulse when the result is complete
rd_en_o  out  1  operand memory read enable
rd_addr_o  out  AW  operand limb address, LSB limb = 0
a_limb_i  in  W  A limb; valid one cycle after rd_en_o
b_limb_i  in  W  B limb; same timing as a_limb_i
p_limb_i  in  W  P limb; same timing as a_limb_i
wr_en_o  out  1  result write enable, both banks
wr_addr_o  out  AW  result limb address
s_limb_o  out  W  S limb to bank 0
t_limb_o  out  W  T limb to bank 1
res_sel_o  out  1  0 = bank 0 (S) holds R, 1 = bank 1 (T); valid from done_o until next start

Behaviour:
- Reset: state IDLE. All of the following are 0: busy_o, done_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, res_sel_o, carry registers c1/c2, op register.
- States: IDLE → ISSUE → DRAIN → DONE → IDLE.
- IDLE, start_i = 1 (cycle 0):
  - Latch op = sub_i.
  - c1 ← op; c2 ← ~op.
  - rd_addr ← 0; next state ISSUE.
  - start_i outside IDLE is ignored; no queueing.
- ISSUE (cycles 1..LIMBS):
  - rd_en_o = 1; rd_addr_o = k on cycle k+1.
  - After address LIMBS−1, go to DRAIN.
- Read latency is 1: limb k data arrives on cycle k+2.
- Compute on cycles 2..LIMBS+1 (limb k on cycle k+2, also the last ISSUE cycles and DRAIN), combinational on the returned data:
  - Adder1: a + (op ? ~b : b) + c1 → s, co1.
  - Adder2: s + (op ? p : ~p) + c2 → t, co2.
  - Register outputs: wr_en_o = 1, wr_addr_o = k, s_limb_o = s, t_limb_o = t.
  - Update c1 ← co1, c2 ← co2.
  - Net effect: write of limb k is visible on cycle k+3.
- DRAIN: covers the final compute/write. Go to DONE once limb LIMBS−1 has been written (wr_en_o high on cycle LIMBS+2).
- DONE (cycle LIMBS+3):
  - done_o = 1 and busy_o = 0 in this cycle.
  - Select rule:
    - Add: res_sel_o ← c1 | c2 (sum overflowed, or S ≥ P).
    - Subtract: res_sel_o ← ~c1 (borrow, so use S + P).
  - Return to IDLE.
  - A start_i in the next IDLE cycle is accepted, so back-to-back operations have a 1-cycle gap.
- busy_o = 1 from cycle 1 through cycle LIMBS+2.
- Carries propagate only limb to limb inside one operation. The final carries are used only for res_sel_o and are discarded afterwards.
- Inputs must satisfy A, B < P; behaviour for out-of-range operands is undefined beyond producing some S/T pair.
- Asynchronous reset mid-operation: immediate return to IDLE with all outputs 0. Partially written result memory contents are don't-care. No done_o pulse.
- Widths: every adder is exactly W bits plus carry-out; there is no wider intermediate.

Test Plan (W=8, LIMBS=2, P=0xFFF1 unless noted):
1. Add, A=0x0001, B=0x0002 → S=0x0003, c1=0, c2=0, res_sel_o=0; done_o exactly on cycle 5 after start; wr_en_o high on cycles 3–4 only.
2. Add, A=0xFFF0, B=0x0005 → S=0xFFF5, T=0x0004, c2=1, res_sel_o=1.
3. Subtract, A=0x0005, B=0x0002 → S=0x0003, c1=1, res_sel_o=0.
4. Subtract, A=0x0002, B=0x0005 → S=0xFFFD, T=0xFFEE, res_sel_o=1.
5. Pulse start_i on cycle 2 of an operation (busy) → ignored. Start in the IDLE cycle after done_o → second result correct. Per-limb write addresses are 0, 1 in order.
6. Assert reset_n low on cycle 3 → all outputs 0 asynchronously, no done_o. A subsequent start yields the correct result. Repeat the W=32, LIMBS=12 configuration with random A, B < P (P = P-384 prime) against a reference model.

Source files
------------

// File: rtl/mod_add_sub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mod_add_sub_seq
//  Purpose  : Limb-serial modular add/subtract sequencer.
//             Computes R = (A + B) mod P or R = (A - B) mod P over LIMBS
//             words of W bits, using two W-bit adders in a carry chain:
//                chain 1 : S = A +/- B
//                chain 2 : T = S -/+ P
//             S limbs go to result bank 0 and T limbs to bank 1. At the end,
//             res_sel_o indicates which bank holds the reduced result.
//  Ports    : clk, reset_n         clock / async active-low reset
//             start_i, sub_i       request and operation select (IDLE only)
//             busy_o, done_o       status; done_o is a one-cycle pulse
//             rd_en_o, rd_addr_o   operand memory read port (latency 1)
//             a/b/p_limb_i         operand limbs returned by the memories
//             wr_en_o, wr_addr_o   result write port, both banks
//             s_limb_o, t_limb_o   bank 0 / bank 1 write data
//             res_sel_o            0 = bank 0 (S) holds R, 1 = bank 1 (T)
//  Revision : 1.0  initial release
// ============================================================================
module mod_add_sub_seq #(
   parameter int W     = 32,
   parameter int LIMBS = 12,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start_i,
   input  logic          sub_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          rd_en_o,
   output logic [AW-1:0] rd_addr_o,
   input  logic [W-1:0]  a_limb_i,
   input  logic [W-1:0]  b_limb_i,
   input  logic [W-1:0]  p_limb_i,
   output logic          wr_en_o,
   output logic [AW-1:0] wr_addr_o,
   output logic [W-1:0]  s_limb_o,
   output logic [W-1:0]  t_limb_o,
   output logic          res_sel_o
);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_ISSUE = 2'd1;
   localparam logic [1:0] c_ST_DRAIN = 2'd2;
   localparam logic [1:0] c_ST_DONE  = 2'd3;

   localparam logic [AW-1:0] c_LAST_ADDR = AW'(LIMBS - 1);

   logic [1:0]    state_q, state_d;
   logic          op_q, op_d;
   logic          c1_q, c1_d;
   logic          c2_q, c2_d;
   logic          rd_en_q, rd_en_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   // Read issue delayed by the memory latency: marks cycles carrying limb data
   logic          vld_q;
   logic [AW-1:0] vaddr_q;
   logic          wr_en_q, wr_en_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [W-1:0]  s_q, s_d;
   logic [W-1:0]  t_q, t_d;
   logic          res_sel_q, res_sel_d;

   // Two's-complement operand conditioning: subtraction uses ~x with the
   // chain's initial carry set to 1 (c1 = op for A-B, c2 = ~op for S-P).
   logic [W-1:0] w_b_op;
   logic [W-1:0] w_p_op;
   logic [W-1:0] w_s;
   logic [W-1:0] w_t;
   logic         w_co1;
   logic         w_co2;

   assign w_b_op = op_q ? ~b_limb_i : b_limb_i;
   assign w_p_op = op_q ? p_limb_i  : ~p_limb_i;

   assign {w_co1, w_s} = {1'b0, a_limb_i} + {1'b0, w_b_op} + {{W{1'b0}}, c1_q};
   assign {w_co2, w_t} = {1'b0, w_s}      + {1'b0, w_p_op} + {{W{1'b0}}, c2_q};

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      c1_d      = c1_q;
      c2_d      = c2_q;
      rd_en_d   = rd_en_q;
      rd_addr_d = rd_addr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      s_d       = s_q;
      t_d       = t_q;
      res_sel_d = res_sel_q;

      case (state_q)
         c_ST_IDLE: begin
            if (start_i) begin
               op_d      = sub_i;
               c1_d      = sub_i;
               c2_d      = ~sub_i;
               rd_en_d   = 1'b1;
               rd_addr_d = '0;
               state_d   = c_ST_ISSUE;
            end
         end
         c_ST_ISSUE: begin
            if (rd_addr_q == c_LAST_ADDR) begin
               rd_en_d   = 1'b0;
               rd_addr_d = '0;
               state_d   = c_ST_DRAIN;
            end else begin
               rd_addr_d = rd_addr_q + 1'b1;
            end
         end
         c_ST_DRAIN: begin
            // Carries are final once the last limb write is on the outputs.
            // Add: overflow or no borrow from S-P means S >= P, so use T.
            // Sub: a borrow out of A-B (c1 = 0) means R = S + P = T.
            if (wr_en_q && (wr_addr_q == c_LAST_ADDR)) begin
               res_sel_d = op_q ? ~c1_q : (c1_q | c2_q);
               state_d   = c_ST_DONE;
            end
         end
         default: begin
            c1_d    = 1'b0;
            c2_d    = 1'b0;
            state_d = c_ST_IDLE;
         end
      endcase

      // Limb compute overlaps the tail of ISSUE and the first DRAIN cycle
      if (vld_q) begin
         wr_en_d   = 1'b1;
         wr_addr_d = vaddr_q;
         s_d       = w_s;
         t_d       = w_t;
         c1_d      = w_co1;
         c2_d      = w_co2;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= c_ST_IDLE;
         op_q      <= 1'b0;
         c1_q      <= 1'b0;
         c2_q      <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         vld_q     <= 1'b0;
         vaddr_q   <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         s_q       <= '0;
         t_q       <= '0;
         res_sel_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         c1_q      <= c1_d;
         c2_q      <= c2_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         vld_q     <= rd_en_q;
         vaddr_q   <= rd_addr_q;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         s_q       <= s_d;
         t_q       <= t_d;
         res_sel_q <= res_sel_d;
      end
   end

   assign busy_o    = (state_q == c_ST_ISSUE) || (state_q == c_ST_DRAIN);
   assign done_o    = (state_q == c_ST_DONE);
   assign rd_en_o   = rd_en_q;
   assign rd_addr_o = rd_addr_q;
   assign wr_en_o   = wr_en_q;
   assign wr_addr_o = wr_addr_q;
   assign s_limb_o  = s_q;
   assign t_limb_o  = t_q;
   assign res_sel_o = res_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_add_sub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_add_sub_seq
//  Purpose  : Self-checking bench for mod_add_sub_seq. A small instance
//             (W=8, LIMBS=2, P=0xFFF1) runs a table of directed vectors and
//             timing/reset sequences; a full-size instance (W=32, LIMBS=12,
//             P = P-384 prime) is compared against a wide-integer model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mod_add_sub_seq;

   localparam logic [15:0]  SP   = 16'hFFF1;
   localparam logic [383:0] P384 = 384'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_00000000_00000000_FFFFFFFF;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset_n;

   int checks = 0;
   int errors = 0;

   // ---------------- small instance ----------------
   logic        s_start, s_sub, s_busy, s_done, s_rd_en, s_wr_en, s_res_sel;
   logic [0:0]  s_rd_addr, s_wr_addr;
   logic [7:0]  s_a_limb, s_b_limb, s_p_limb, s_s_limb, s_t_limb;
   logic [15:0] s_a, s_b, s_bank0, s_bank1;

   mod_add_sub_seq #(.W(8), .LIMBS(2), .AW(1)) u_small (
      .clk(clk), .reset_n(reset_n), .start_i(s_start), .sub_i(s_sub),
      .busy_o(s_busy), .done_o(s_done), .rd_en_o(s_rd_en), .rd_addr_o(s_rd_addr),
      .a_limb_i(s_a_limb), .b_limb_i(s_b_limb), .p_limb_i(s_p_limb),
      .wr_en_o(s_wr_en), .wr_addr_o(s_wr_addr), .s_limb_o(s_s_limb),
      .t_limb_o(s_t_limb), .res_sel_o(s_res_sel)
   );

   always @(posedge clk) begin
      if (s_rd_en) begin
         s_a_limb <= s_a[{s_rd_addr, 3'b000} +: 8];
         s_b_limb <= s_b[{s_rd_addr, 3'b000} +: 8];
         s_p_limb <= SP[{s_rd_addr, 3'b000} +: 8];
      end
      if (s_wr_en) begin
         s_bank0[{s_wr_addr, 3'b000} +: 8] <= s_s_limb;
         s_bank1[{s_wr_addr, 3'b000} +: 8] <= s_t_limb;
      end
   end

   // ---------------- full-size instance ----------------
   logic         b_start, b_sub, b_busy, b_done, b_rd_en, b_wr_en, b_res_sel;
   logic [3:0]   b_rd_addr, b_wr_addr;
   logic [31:0]  b_a_limb, b_b_limb, b_p_limb, b_s_limb, b_t_limb;
   logic [383:0] b_a, b_b, b_bank0, b_bank1;

   mod_add_sub_seq #(.W(32), .LIMBS(12), .AW(4)) u_big (
      .clk(clk), .reset_n(reset_n), .start_i(b_start), .sub_i(b_sub),
      .busy_o(b_busy), .done_o(b_done), .rd_en_o(b_rd_en), .rd_addr_o(b_rd_addr),
      .a_limb_i(b_a_limb), .b_limb_i(b_b_limb), .p_limb_i(b_p_limb),
      .wr_en_o(b_wr_en), .wr_addr_o(b_wr_addr), .s_limb_o(b_s_limb),
      .t_limb_o(b_t_limb), .res_sel_o(b_res_sel)
   );

   always @(posedge clk) begin
      if (b_rd_en) begin
         b_a_limb <= b_a[{b_rd_addr, 5'b00000} +: 32];
         b_b_limb <= b_b[{b_rd_addr, 5'b00000} +: 32];
         b_p_limb <= P384[{b_rd_addr, 5'b00000} +: 32];
      end
      if (b_wr_en) begin
         b_bank0[{b_wr_addr, 5'b00000} +: 32] <= b_s_limb;
         b_bank1[{b_wr_addr, 5'b00000} +: 32] <= b_t_limb;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] small_ref(input bit sub, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] x;
      if (!sub) begin
         x = {1'b0, a} + {1'b0, b};
         if (x >= {1'b0, SP}) x = x - {1'b0, SP};
      end else begin
         x = (a >= b) ? {1'b0, a - b} : ({1'b0, a} + {1'b0, SP} - {1'b0, b});
      end
      return x[15:0];
   endfunction

   function automatic logic [383:0] big_ref(input bit sub, input logic [383:0] a, input logic [383:0] b);
      logic [384:0] x;
      if (!sub) begin
         x = {1'b0, a} + {1'b0, b};
         if (x >= {1'b0, P384}) x = x - {1'b0, P384};
      end else begin
         x = (a >= b) ? {1'b0, a - b} : ({1'b0, a} + {1'b0, P384} - {1'b0, b});
      end
      return x[383:0];
   endfunction

   function automatic logic [383:0] rand_fe();
      logic [383:0] x;
      for (int i = 0; i < 12; i++) x[i*32 +: 32] = $urandom();
      if (x >= P384) x = x - P384;
      return x;
   endfunction

   // Cycle 0 is the cycle in which start_i is high. Optionally pulses start_i
   // again on cycle 'inj' while the operation is running.
   task automatic run_small(input bit sub, input logic [15:0] a, input logic [15:0] b,
                            input int inj, output int done_cyc,
                            output logic [7:0] wr_mask, output logic [7:0] busy_mask,
                            output logic [1:0] wr_addrs);
      int nwr;
      s_a = a; s_b = b;
      done_cyc = -1; wr_mask = '0; busy_mask = '0; wr_addrs = 2'b11; nwr = 0;
      @(negedge clk); s_start = 1'b1; s_sub = sub;
      @(negedge clk);
      for (int cyc = 1; cyc < 40; cyc++) begin
         s_start = (cyc == inj);
         if (cyc < 8) begin
            wr_mask[cyc]   = s_wr_en;
            busy_mask[cyc] = s_busy;
         end
         if (s_wr_en && nwr < 2) begin
            wr_addrs[nwr] = s_wr_addr[0];
            nwr++;
         end
         if (s_done) begin
            done_cyc = cyc;
            break;
         end
         @(negedge clk);
      end
      s_start = 1'b0;
   endtask

   task automatic run_big(input bit sub, input logic [383:0] a, input logic [383:0] b,
                          output int done_cyc);
      b_a = a; b_b = b; done_cyc = -1;
      @(negedge clk); b_start = 1'b1; b_sub = sub;
      @(negedge clk); b_start = 1'b0;
      for (int cyc = 1; cyc < 60; cyc++) begin
         if (b_done) begin
            done_cyc = cyc;
            break;
         end
         @(negedge clk);
      end
   endtask

   typedef struct {
      bit          sub;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] s;
      logic [15:0] t;
      bit          sel;
   } vec_t;

   vec_t vt[9];

   task automatic check_small_vec(input vec_t v, input string tag, input int inj);
      int         dc;
      logic [7:0] wm, bm;
      logic [1:0] wa;
      logic [15:0] r;
      run_small(v.sub, v.a, v.b, inj, dc, wm, bm, wa);
      chk({tag, "_done_cycle"}, 384'(dc), 384'(5));
      chk({tag, "_S"}, 384'(s_bank0), 384'(v.s));
      chk({tag, "_T"}, 384'(s_bank1), 384'(v.t));
      chk({tag, "_sel"}, 384'(s_res_sel), 384'(v.sel));
      r = s_res_sel ? s_bank1 : s_bank0;
      chk({tag, "_R"}, 384'(r), 384'(small_ref(v.sub, v.a, v.b)));
      chk({tag, "_wr_cycles"}, 384'(wm), 384'(8'b0001_1000));
      chk({tag, "_busy_cycles"}, 384'(bm), 384'(8'b0001_1110));
      chk({tag, "_wr_addrs"}, 384'(wa), 384'(2'b10));
   endtask

   initial begin
      int   dc;
      logic seen_done;
      logic [383:0] ra, rb;

      //           sub   A        B        S        T        sel
      vt[0] = '{1'b0, 16'h0001, 16'h0002, 16'h0003, 16'h0012, 1'b0};
      vt[1] = '{1'b0, 16'hFFF0, 16'h0005, 16'hFFF5, 16'h0004, 1'b1};
      vt[2] = '{1'b1, 16'h0005, 16'h0002, 16'h0003, 16'hFFF4, 1'b0};
      vt[3] = '{1'b1, 16'h0002, 16'h0005, 16'hFFFD, 16'hFFEE, 1'b1};
      vt[4] = '{1'b0, 16'hFFF0, 16'hFFF0, 16'hFFE0, 16'hFFEF, 1'b1};
      vt[5] = '{1'b0, 16'h0008, 16'hFFE9, 16'hFFF1, 16'h0000, 1'b1};
      vt[6] = '{1'b1, 16'h0007, 16'h0007, 16'h0000, 16'hFFF1, 1'b0};
      vt[7] = '{1'b0, 16'h00FF, 16'h0001, 16'h0100, 16'h010F, 1'b0};
      vt[8] = '{1'b1, 16'h0100, 16'h0001, 16'h00FF, 16'h00F0, 1'b0};

      reset_n = 1'b0;
      s_start = 1'b0; s_sub = 1'b0; s_a = '0; s_b = '0;
      b_start = 1'b0; b_sub = 1'b0; b_a = '0; b_b = '0;
      repeat (3) @(negedge clk);

      chk("reset_small_outputs",
          384'({s_busy, s_done, s_rd_en, s_rd_addr, s_wr_en, s_wr_addr, s_res_sel, s_s_limb, s_t_limb}),
          384'(0));
      chk("reset_big_outputs",
          384'({b_busy, b_done, b_rd_en, b_rd_addr, b_wr_en, b_wr_addr, b_res_sel, b_s_limb, b_t_limb}),
          384'(0));
      reset_n = 1'b1;

      // Directed vectors, back-to-back with the minimum gap
      for (int i = 0; i < 9; i++) check_small_vec(vt[i], $sformatf("vec%0d", i), 0);

      // start_i pulsed on cycle 2 while busy must be ignored; then a start
      // in the IDLE cycle right after done_o
      check_small_vec(vt[0], "busy_start", 2);
      check_small_vec(vt[1], "after_done", 0);

      // Asynchronous reset on cycle 3 of an operation (res_sel is 1 here)
      s_a = vt[2].a; s_b = vt[2].b;
      @(negedge clk); s_start = 1'b1; s_sub = vt[2].sub;
      @(negedge clk); s_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_wr_en", 384'(s_wr_en), 384'(1));
      reset_n = 1'b0;
      #1;
      chk("async_reset_outputs",
          384'({s_busy, s_done, s_rd_en, s_rd_addr, s_wr_en, s_wr_addr, s_res_sel, s_s_limb, s_t_limb}),
          384'(0));
      seen_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         seen_done = seen_done | s_done | s_busy;
      end
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         seen_done = seen_done | s_done | s_busy;
      end
      chk("no_done_after_reset", 384'(seen_done), 384'(0));
      check_small_vec(vt[3], "post_reset", 0);

      // Full-size configuration against the wide-integer model
      for (int i = 0; i < 8; i++) begin
         case (i)
            0: begin ra = P384 - 1; rb = P384 - 1; end
            1: begin ra = '0;       rb = P384 - 1; end
            2: begin ra = rand_fe(); rb = ra;      end
            default: begin ra = rand_fe(); rb = rand_fe(); end
         endcase
         run_big(i[0], ra, rb, dc);
         chk($sformatf("big%0d_done_cycle", i), 384'(dc), 384'(15));
         chk($sformatf("big%0d_R", i), b_res_sel ? b_bank1 : b_bank0, big_ref(i[0], ra, rb));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
